// File: rtl/pattern_matcher_pkg.sv
// pattern_matcher_pkg: shared constants and helpers for pattern_matcher
package pattern_matcher_pkg;
    localparam int LEN_MIN = 2;
    localparam int LEN_MAX = 32;
    function automatic int fill_w(input int len);
        return $clog2(len);
    endfunction
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [32:0] max;
        max = (33'd1 << width) - 33'd1;
        return (value >= max[31:0]) ? value : value + 32'd1;
    endfunction
endpackage

// File: rtl/pm_sat_counter.sv
// pm_sat_counter: CNT_W-bit saturating counter with priority synchronous clear
//   clk, rst (async, active high), clr (wins over inc), inc, count
module pm_sat_counter
    import pattern_matcher_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= CNT_W'(sat_inc(32'(count), CNT_W));
endmodule

// File: rtl/pattern_matcher.sv
// pattern_matcher: serial detector of a loadable LEN-bit pattern with don't-care mask
//   clk, rst (async, active high)
//   cfg_load, pattern_in, mask_in: load pattern/mask, flush history
//   overlap: 1 = overlapping matches, 0 = restart after a match
//   in_valid, x: serial stream bit; y: Mealy match strobe
//   cnt_clr, match_count: saturating match counter, only with PATTERN_MATCHER_CNT_EN
module pattern_matcher
    import pattern_matcher_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [LEN-1:0]   pattern_in,
    input  logic [LEN-1:0]   mask_in,
    input  logic             overlap,
    input  logic             in_valid,
    input  logic             x,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count
);
    localparam int FW = fill_w(LEN);
    localparam int HW = LEN - 1;
    localparam logic [FW-1:0] FULL = FW'(LEN - 1);
    logic [LEN-1:0] pattern_q, mask_q;
    logic [HW-1:0]  hist;
    logic [FW-1:0]  fill;
    logic           restart;
    assign y = in_valid & ~cfg_load & (fill == FULL) & ~|(({hist, x} ^ pattern_q) & mask_q);
    assign restart = y & ~overlap;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pattern_q <= '0;
            mask_q    <= '0;
            hist      <= '0;
            fill      <= '0;
        end else if (cfg_load) begin
            pattern_q <= pattern_in;
            mask_q    <= mask_in;
            hist      <= '0;
            fill      <= '0;
        end else if (in_valid) begin
            // truncating cast drops the oldest bit of the shifted window
            hist <= restart ? '0 : HW'({hist, x});
            fill <= restart ? '0 : (fill == FULL) ? fill : fill + 1'b1;
        end
`ifdef PATTERN_MATCHER_CNT_EN
    pm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (y),
        .count(match_count)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count = '0;
`endif
endmodule

// File: tb/tb_pattern_matcher.sv
// tb_pattern_matcher: directed scoreboard bench for pattern_matcher (LEN=4, CNT_W=2)
module tb_pattern_matcher;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_load = 1'b0;
    logic [3:0] pattern_in = '0;
    logic [3:0] mask_in = '0;
    logic       overlap = 1'b1;
    logic       in_valid = 1'b0;
    logic       x = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       y;
    logic [1:0] match_count;
    int tests = 0;
    int fails = 0;
    logic        yq[$];
    logic [31:0] cq[$];
    logic [3:0] mpat, mmask;
    logic [2:0] mhist;
    int mfill, mcnt;
    logic [2:0] g3;
    int gn;
    bit use_fixed = 1'b0;

    pattern_matcher #(.LEN(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .pattern_in (pattern_in),
        .mask_in    (mask_in),
        .overlap    (overlap),
        .in_valid   (in_valid),
        .x          (x),
        .cnt_clr    (cnt_clr),
        .y          (y),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mpat = '0; mmask = '0; mhist = '0; mfill = 0; mcnt = 0; g3 = '0; gn = 0;
    endtask

    // called 1 time unit after a rising edge; returns 1 time unit after the next one
    task automatic step(input string tag, input logic v, input logic b,
                        input logic cl = 1'b0, input logic cc = 1'b0);
        logic eg, ef;
        in_valid = v; x = b; cfg_load = cl; cnt_clr = cc;
        eg = v & ~cl & (mfill == 3) & ((({mhist, b} ^ mpat) & mmask) == 4'b0);
        ef = v & ~cl & (gn >= 3) & g3[2] & ~b;
        yq.push_back(use_fixed ? ef : eg);
        #3;
        check({tag, "_y"}, {31'b0, y}, {31'b0, yq.pop_front()});
        if (cl) begin
            mpat = pattern_in; mmask = mask_in; mhist = '0; mfill = 0; g3 = '0; gn = 0;
        end else if (v) begin
            if (eg && !overlap) begin
                mhist = '0; mfill = 0;
            end else begin
                mhist = {mhist[1:0], b}; mfill = (mfill < 3) ? mfill + 1 : 3;
            end
            g3 = {g3[1:0], b}; gn++;
        end
`ifdef PATTERN_MATCHER_CNT_EN
        if (cc) mcnt = 0;
        else if (eg && mcnt < 3) mcnt++;
`endif
        cq.push_back(mcnt);
        @(posedge clk); #1;
        check({tag, "_cnt"}, {30'b0, match_count}, cq.pop_front());
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic stream(input string tag, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i]);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b1; x = 1'b0;
        #1;
        check("reset_y", {31'b0, y}, 32'd0);
        check("reset_cnt", {30'b0, match_count}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // 1XX0 equivalence against the fixed detector
        pattern_in = 4'b1000; mask_in = 4'b1001; overlap = 1'b1;
        step("cfg1", 1'b0, 1'b0, 1'b1);
        use_fixed = 1'b1;
        stream("x1xx0", 16'b1010110, 7);
        use_fixed = 1'b0;

        // overlapping vs restart-after-match
        pattern_in = 4'b1010; mask_in = 4'b1111; overlap = 1'b1;
        step("cfg_ov", 1'b0, 1'b0, 1'b1, 1'b1);
        stream("ov1", 16'b101010, 6);
        overlap = 1'b0;
        step("cfg_nov", 1'b0, 1'b0, 1'b1, 1'b1);
        stream("ov0", 16'b101010, 6);

        // stream gaps keep a partial match; cfg_load with a valid bit discards it
        overlap = 1'b1;
        step("cfg_gap", 1'b0, 1'b0, 1'b1);
        stream("gap_a", 16'b10, 2);
        repeat (3) step("gap_idle", 1'b0, 1'b1);
        stream("gap_b", 16'b10, 2);
        stream("ld_a", 16'b10, 2);
        step("ld_bit", 1'b1, 1'b1, 1'b1);
        stream("ld_b", 16'b0101010, 7);

        // counter saturation and clear priority over a match
        mask_in = 4'b0000;
        step("cfg_sat", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step("sat", 1'b1, 1'($urandom_range(1)));
        step("clr_hit", 1'b1, 1'b0, 1'b0, 1'b1);
        step("after_clr", 1'b1, 1'b1);

        // asynchronous reset in the middle of a partial match
        mask_in = 4'b1111; overlap = 1'b0;
        step("cfg_ar", 1'b0, 1'b0, 1'b1, 1'b1);
        stream("ar_pre", 16'b1010101, 7);
        in_valid = 1'b1; x = 1'b0;
        #1;
        check("ar_before_y", {31'b0, y}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_y", {31'b0, y}, 32'd0);
        check("ar_cnt", {30'b0, match_count}, 32'd0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        overlap = 1'b1;
        stream("ar_post", 16'b10100, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
